// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Two-master arbiter in front of a single-port instruction memory with a
//   combinational read path. A fetch port (read only) and a loader port
//   (read/write) compete for the memory; responses come back exactly one cycle
//   after the grant as a single-cycle rvalid pulse.
//
//   Arbitration when both request:
//     default                  : loader wins (fixed priority)
//     IMEM_ARB_ROUND_ROBIN_EN  : the requester not granted last time wins,
//                                fetch wins when there is no history
//   In both modes fetch is forced once the loader has taken MAX_BURST
//   consecutive grants while fetch was waiting.
//
// Parameters
//   MAX_BURST  max consecutive loader grants while fetch requests (1..15)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   f_req, f_addr                fetch request / byte address
//   f_gnt, f_rvalid, f_rdata     fetch grant, response valid, instruction
//   l_req, l_we, l_addr, l_wdata loader request, write enable, address, data
//   l_gnt, l_rvalid, l_rdata     loader grant, response/ack valid, read data
//   m_addr, m_we, m_wdata        memory address, write enable, write data
//   m_rdata                      memory read data (combinational on m_addr)
// -----------------------------------------------------------------------------
module imem_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [31:0] f_rdata,
   input  logic        l_req,
   input  logic        l_we,
   input  logic [31:0] l_addr,
   input  logic [31:0] l_wdata,
   output logic        l_gnt,
   output logic        l_rvalid,
   output logic [31:0] l_rdata,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   logic [1:0]  state_q, state_d;
   logic [3:0]  burst_cnt_q, burst_cnt_d;
   logic [31:0] f_rdata_q, f_rdata_d;
   logic [31:0] l_rdata_q, l_rdata_d;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic        both_req;
   logic        burst_full;
   logic        load_wins;

   assign both_req   = f_req & l_req;
   assign burst_full = (burst_cnt_q == BURST_LIMIT);

`ifdef IMEM_ARB_ROUND_ROBIN_EN
   // Winner of the most recent grant; unlike state_q it survives idle cycles.
   // ST_IDLE here means no grant since reset.
   logic [1:0] last_gnt_q, last_gnt_d;

   assign load_wins = both_req ? (!burst_full && (last_gnt_q == ST_FETCH)) : l_req;
   assign last_gnt_d = (state_d != ST_IDLE) ? state_d : last_gnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_gnt_q <= ST_IDLE;
      else        last_gnt_q <= last_gnt_d;
   end
`else
   assign load_wins = both_req ? !burst_full : l_req;
`endif

   // Grants are gated by rst_n so nothing is granted while reset is held.
   assign l_gnt = rst_n & load_wins;
   assign f_gnt = rst_n & f_req & ~load_wins;

   // Memory side follows the granted port; hold the last values otherwise.
   assign m_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : m_addr_q);
   assign m_we    = l_gnt & l_we;
   assign m_wdata = m_we ? l_wdata : m_wdata_q;

   always_comb begin
      state_d     = ST_IDLE;
      burst_cnt_d = burst_cnt_q;
      f_rdata_d   = f_rdata_q;
      l_rdata_d   = l_rdata_q;
      if (f_gnt) begin
         state_d     = ST_FETCH;
         burst_cnt_d = '0;
         f_rdata_d   = m_rdata;
      end else if (l_gnt) begin
         state_d   = ST_LOAD;
         l_rdata_d = l_we ? '0 : m_rdata;
         if (f_req) burst_cnt_d = burst_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= '0;
         f_rdata_q   <= '0;
         l_rdata_q   <= '0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         f_rdata_q   <= f_rdata_d;
         l_rdata_q   <= l_rdata_d;
         m_addr_q    <= m_addr;
         m_wdata_q   <= m_wdata;
      end
   end

   // The state records who was granted last cycle, which is exactly who
   // owes a response this cycle.
   assign f_rvalid = (state_q == ST_FETCH);
   assign l_rvalid = (state_q == ST_LOAD);
   assign f_rdata  = f_rdata_q;
   assign l_rdata  = l_rdata_q;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive loader grants while fetch is requesting (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port f_req, input, 1 bit: fetch read request.
REQ-005 SHALL have port f_addr, input, 32 bits: fetch byte address.
REQ-006 SHALL have port f_gnt, output, 1 bit: fetch granted this cycle.
REQ-007 SHALL have port f_rvalid, output, 1 bit: fetch response valid.
REQ-008 SHALL have port f_rdata, output, 32 bits: fetch response instruction.
REQ-009 SHALL have port l_req, input, 1 bit: loader request.
REQ-010 SHALL have port l_we, input, 1 bit: loader write when 1, read when 0.
REQ-011 SHALL have port l_addr, input, 32 bits: loader byte address.
REQ-012 SHALL have port l_wdata, input, 32 bits: loader write data.
REQ-013 SHALL have port l_gnt, output, 1 bit: loader granted this cycle.
REQ-014 SHALL have port l_rvalid, output, 1 bit: loader response or write acknowledge.
REQ-015 SHALL have port l_rdata, output, 32 bits: loader read data.
REQ-016 SHALL have port m_addr, output, 32 bits: address to the instruction memory.
REQ-017 SHALL have port m_we, output, 1 bit: memory write enable.
REQ-018 SHALL have port m_wdata, output, 32 bits: memory write data.
REQ-019 SHALL have port m_rdata, input, 32 bits: combinational memory read data for m_addr.

Function
REQ-020 SHALL make f_gnt and l_gnt combinational from the requests and the arbiter state, and SHALL never assert both in the same cycle.
REQ-021 SHALL assert no grant when neither f_req nor l_req is asserted; m_we SHALL be 0, and m_addr and m_wdata SHALL hold their last values.
REQ-022 SHALL grant the only requester when exactly one requester is asserted.
REQ-023 SHALL, in the cycle of a grant, drive m_addr from the granted address and assert m_we only for a loader grant with l_we=1.
REQ-024 SHALL give responses a latency of exactly 1 cycle: the cycle after f_gnt, f_rvalid=1 and f_rdata is m_rdata as registered at the grant.
REQ-025 SHALL, the cycle after a loader read grant, assert l_rvalid=1 with l_rdata equal to the registered m_rdata.
REQ-026 SHALL, the cycle after a loader write grant, assert l_rvalid=1 with l_rdata=0.
REQ-027 SHALL keep rvalid as a 1-cycle pulse with no backpressure; the requester is responsible for capturing it.
REQ-028 SHALL hold f_rdata and l_rdata at their last values while their rvalid is 0.
REQ-029 SHALL implement a state machine with states IDLE (no grant last cycle), FETCH (fetch granted last cycle) and LOAD (loader granted last cycle); the state becomes whichever requester is granted, or IDLE when there is no grant.
REQ-030 SHALL maintain a 4-bit burst_cnt: increment it on each loader grant while f_req=1, clear it on any fetch grant, and leave it unchanged otherwise.
REQ-031 SHALL, when both requesters are asserted and burst_cnt==MAX_BURST, grant fetch regardless of the arbitration mode.
REQ-032 SHALL accept back-to-back grants every cycle, with address changes under grant honoured immediately.
REQ-033 SHALL pass addresses to memory unmodified; word alignment is the memory's concern.

Reset
REQ-034 SHALL, while rst_n=0, force state=IDLE, burst_cnt=0, f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0, m_addr=0, m_wdata=0 and m_we=0.
REQ-035 SHALL, when reset is asserted mid-operation, discard any pending response, so that no rvalid occurs for a grant issued in the cycle reset asserted.
REQ-036 SHALL ignore requests while rst_n=0 and issue no grants.

Configuration
REQ-037 SHALL support the macro IMEM_ARB_ROUND_ROBIN_EN; when it is defined and both requesters are asserted, the requester not granted in the previous grant cycle wins (fetch on a tie out of IDLE with no history), subject to REQ-031.
REQ-038 SHALL, when IMEM_ARB_ROUND_ROBIN_EN is undefined, use fixed priority with loader winning over fetch, subject to REQ-031.

Verification
REQ-039 The bench SHALL cover: f_req=1 alone with f_addr=0x8 and memory word[2]=0x00409093 -> f_gnt=1 and, next cycle, f_rvalid=1 with f_rdata=0x00409093.
REQ-040 The bench SHALL cover: a loader write with l_addr=0x10 and l_wdata=0xDEADBEEF, then a fetch of 0x10 -> l_rvalid=1 with l_rdata=0, then f_rdata=0xDEADBEEF.
REQ-041 The bench SHALL cover: fixed priority, MAX_BURST=4, f_req and l_req held high for 10 cycles -> grant pattern L,L,L,L,F,L,L,L,L,F.
REQ-042 The bench SHALL cover: IMEM_ARB_ROUND_ROBIN_EN defined, both requesters held high for 6 cycles from IDLE -> grant pattern F,L,F,L,F,L.
REQ-043 The bench SHALL cover: rst_n dropped in a cycle with f_gnt=1 -> f_rvalid stays 0 and all outputs read 0 until release.
REQ-044 The bench SHALL cover: no requests for 5 cycles after traffic -> no grants, m_we=0, and both rvalids are 0.
